// File: rtl/l1_bus_pkg.sv
// l1_bus_pkg: shared size encodings, controller states and line-address helper.
package l1_bus_pkg;
  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0010;
  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_D = 4'b1000;
  localparam int LINE_WORDS_DEF = 256;
  typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_RD, ST_WR, ST_DONE} state_t;
  function automatic logic [63:0] line_base(input logic [63:0] a, input int words);
    return a & ~((64'(words) << 3) - 64'd1);
  endfunction
endpackage

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr: counts cycles of an outstanding beat, flags on the TIMEOUT-th cycle.
module bus_timeout_ctr #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d   = active ? cnt_q + W'(1) : '0;
    expired = active && (cnt_q == W'(TIMEOUT - 1));
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/l1_refill_ctrl.sv
// l1_refill_ctrl: turns L1 fill/read/write-through requests into single-beat req/ack bus transactions.
module l1_refill_ctrl
  import l1_bus_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_through_req,
  input  logic        read_req,
  input  logic        read_line_req,
  input  logic [3:0]  L1_size,
  input  logic [63:0] pa,
  input  logic [63:0] wt_data,
  output logic [63:0] line_data,
  output logic [10:0] addr_count,
  output logic        line_write,
  output logic        cache_entry_write,
  output logic        trans_rdy,
  output logic        bus_error,
  output logic        line_fill_abort,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [3:0]  bus_size,
  output logic [63:0] bus_wdata,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);
  state_t      state_q, state_d;
  logic [11:0] beat_q, beat_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, line_data_q, line_data_d;
  logic [10:0] addr_count_q, addr_count_d;
  logic [3:0]  size_q, size_d;
  logic        gap_q, gap_d, we_q, we_d;
  logic        line_write_q, line_write_d, cew_q, cew_d, trans_q, trans_d;
  logic        berr_q, berr_d, abort_q, abort_d;
  logic        active, expired, fail;

  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk), .rst(rst), .active(active), .expired(expired)
  );

  always_comb begin
    active       = (state_q == ST_FILL || state_q == ST_RD || state_q == ST_WR) && !gap_q;
    fail         = active && (bus_err || expired);
    state_d      = state_q;
    beat_d       = beat_q;
    gap_d        = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    we_d         = we_q;
    line_data_d  = line_data_q;
    addr_count_d = addr_count_q;
    line_write_d = 1'b0;
    cew_d        = 1'b0;
    trans_d      = 1'b0;
    berr_d       = 1'b0;
    abort_d      = 1'b0;
    if (fail) begin
      state_d = ST_DONE;
      berr_d  = 1'b1;
      abort_d = state_q == ST_FILL && beat_q != '0;
    end else begin
      case (state_q)
        ST_IDLE:
          if (read_line_req || read_req || write_through_req) begin
            addr_d  = pa;
            wdata_d = wt_data;
            size_d  = read_line_req ? SZ_D : L1_size;
            we_d    = !read_line_req && !read_req;
            beat_d  = '0;
            state_d = read_line_req ? ST_FILL : read_req ? ST_RD : ST_WR;
          end
        ST_FILL:
          if (gap_q) begin
            // the gap after the last beat's line_write carries the completion
            if (beat_q == 12'(LINE_WORDS)) begin
              cew_d   = 1'b1;
              trans_d = 1'b1;
              state_d = ST_DONE;
            end
          end else if (bus_ack) begin
            line_data_d  = bus_rdata;
            line_write_d = 1'b1;
            addr_count_d = beat_q[10:0];
            beat_d       = beat_q + 12'd1;
            gap_d        = 1'b1;
          end
        ST_RD:
          if (bus_ack) begin
            line_data_d = bus_rdata;
            trans_d     = 1'b1;
            state_d     = ST_DONE;
          end
        ST_WR:
          if (bus_ack) begin
            trans_d = 1'b1;
            state_d = ST_DONE;
          end
        default: state_d = ST_IDLE;
      endcase
    end
    bus_req   = active;
    bus_we    = active && we_q;
    bus_size  = active ? size_q : '0;
    bus_wdata = active ? wdata_q : '0;
    bus_addr  = !active ? '0 :
                state_q == ST_FILL ? line_base(addr_q, LINE_WORDS) | (64'(beat_q) << 3) : addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      gap_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      line_data_q  <= '0;
      addr_count_q <= '0;
      line_write_q <= 1'b0;
      cew_q        <= 1'b0;
      trans_q      <= 1'b0;
      berr_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      gap_q        <= gap_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      we_q         <= we_d;
      line_data_q  <= line_data_d;
      addr_count_q <= addr_count_d;
      line_write_q <= line_write_d;
      cew_q        <= cew_d;
      trans_q      <= trans_d;
      berr_q       <= berr_d;
      abort_q      <= abort_d;
    end
  end

  assign line_data         = line_data_q;
  assign addr_count        = addr_count_q;
  assign line_write        = line_write_q;
  assign cache_entry_write = cew_q;
  assign trans_rdy         = trans_q;
  assign bus_error         = berr_q;
  assign line_fill_abort   = abort_q;
endmodule

// File: tb/tb_l1_refill_ctrl.sv
// tb_l1_refill_ctrl: directed scenario tasks for the L1 refill controller (LINE_WORDS=4, TIMEOUT=8).
module tb_l1_refill_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        write_through_req = 0, read_req = 0, read_line_req = 0;
  logic [3:0]  L1_size = '0;
  logic [63:0] pa = '0, wt_data = '0, bus_rdata = '0;
  logic        bus_ack = 0, bus_err = 0;
  logic [63:0] line_data, bus_addr, bus_wdata;
  logic [10:0] addr_count;
  logic [3:0]  bus_size;
  logic        line_write, cache_entry_write, trans_rdy, bus_error, line_fill_abort, bus_req, bus_we;
  int checks = 0, failures = 0;
  int n_lw = 0, n_cew = 0, n_tr = 0, n_be = 0, n_ab = 0, n_cewtr = 0;
  logic [10:0] lw_cnt[64];
  logic [63:0] lw_dat[64];

  l1_refill_ctrl #(.LINE_WORDS(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .write_through_req(write_through_req), .read_req(read_req),
    .read_line_req(read_line_req), .L1_size(L1_size), .pa(pa), .wt_data(wt_data),
    .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
    .cache_entry_write(cache_entry_write), .trans_rdy(trans_rdy), .bus_error(bus_error),
    .line_fill_abort(line_fill_abort), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_size(bus_size), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (line_write && n_lw < 64) begin
      lw_cnt[n_lw] = addr_count;
      lw_dat[n_lw] = line_data;
    end
    if (line_write) n_lw++;
    if (cache_entry_write) n_cew++;
    if (trans_rdy) n_tr++;
    if (bus_error) n_be++;
    if (line_fill_abort) n_ab++;
    if (cache_entry_write && trans_rdy) n_cewtr++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string nm);
    for (int i = 0; i < 20 && bus_req !== 1'b1; i++) step();
    checks++;
    if (bus_req !== 1'b1) begin failures++; $display("FAIL %s bus_req got=%b exp=1", nm, bus_req); end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) step();
    checks++;
    if ({line_data, addr_count, line_write, cache_entry_write, trans_rdy, bus_error, line_fill_abort,
         bus_req, bus_we, bus_addr, bus_size, bus_wdata} !== '0) begin
      failures++; $display("FAIL reset_outputs got line_data=%0h bus_req=%b bus_addr=%0h exp=0", line_data, bus_req, bus_addr);
    end
    rst = 0;
    step();
  endtask

  task automatic test_fill();
    int lw0 = n_lw, cew0 = n_cew, tr0 = n_tr, ct0 = n_cewtr;
    logic [63:0] ea;
    read_line_req = 1; pa = 64'h8000_0A38;
    for (int b = 0; b < 4; b++) begin
      wait_req("fill_req");
      ea = 64'h8000_0A20 + 64'(b) * 8;
      checks++;
      if (bus_addr !== ea || bus_size !== 4'b1000 || bus_we !== 1'b0) begin
        failures++; $display("FAIL fill_addr beat %0d got=%0h/%b/%b exp=%0h/1000/0", b, bus_addr, bus_size, bus_we, ea);
      end
      step();
      bus_ack = 1; bus_rdata = 64'(b);
      step();
      bus_ack = 0;
      checks++;
      if (bus_req !== 1'b0 || line_write !== 1'b1 || addr_count !== 11'(b) || line_data !== 64'(b)) begin
        failures++; $display("FAIL fill_beat %0d got req=%b lw=%b cnt=%0d data=%0h exp req=0 lw=1 cnt=%0d data=%0d", b, bus_req, line_write, addr_count, line_data, b, b);
      end
    end
    step();
    checks++;
    if (cache_entry_write !== 1'b1 || trans_rdy !== 1'b1 || line_write !== 1'b0) begin
      failures++; $display("FAIL fill_done got cew=%b tr=%b lw=%b exp 1 1 0", cache_entry_write, trans_rdy, line_write);
    end
    read_line_req = 0;
    repeat (3) step();
    checks++;
    if (n_lw - lw0 != 4 || n_cew - cew0 != 1 || n_tr - tr0 != 1 || n_cewtr - ct0 != 1) begin
      failures++; $display("FAIL fill_counts got lw=%0d cew=%0d tr=%0d exp 4 1 1", n_lw - lw0, n_cew - cew0, n_tr - tr0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lw_cnt[lw0 + i] !== 11'(i) || lw_dat[lw0 + i] !== 64'(i)) begin
        failures++; $display("FAIL fill_lw %0d got cnt=%0d data=%0h exp %0d", i, lw_cnt[lw0 + i], lw_dat[lw0 + i], i);
      end
    end
  endtask

  task automatic test_read();
    int lw0 = n_lw, tr0 = n_tr;
    read_req = 1; pa = 64'h1000_0004; L1_size = 4'b0100;
    wait_req("read_req");
    checks++;
    if (bus_addr !== 64'h1000_0004 || bus_size !== 4'b0100 || bus_we !== 1'b0) begin
      failures++; $display("FAIL read_bus got=%0h/%b/%b exp=10000004/0100/0", bus_addr, bus_size, bus_we);
    end
    repeat (4) step();
    bus_ack = 1; bus_rdata = 64'hDEAD_BEEF;
    step();
    bus_ack = 0;
    checks++;
    if (trans_rdy !== 1'b1 || line_data !== 64'hDEAD_BEEF) begin
      failures++; $display("FAIL read_done got tr=%b data=%0h exp 1 deadbeef", trans_rdy, line_data);
    end
    read_req = 0;
    repeat (2) step();
    checks++;
    if (n_lw != lw0 || n_tr - tr0 != 1 || line_data !== 64'hDEAD_BEEF) begin
      failures++; $display("FAIL read_after got lw=%0d tr=%0d data=%0h exp 0 1 deadbeef", n_lw - lw0, n_tr - tr0, line_data);
    end
  endtask

  task automatic test_write();
    int tr0 = n_tr;
    write_through_req = 1; pa = 64'h2000_0010; wt_data = 64'h1122_3344_5566_7788; L1_size = 4'b1000;
    wait_req("write_req");
    checks++;
    if (bus_we !== 1'b1 || bus_addr !== 64'h2000_0010 || bus_size !== 4'b1000 || bus_wdata !== 64'h1122_3344_5566_7788) begin
      failures++; $display("FAIL write_bus got we=%b addr=%0h size=%b wd=%0h", bus_we, bus_addr, bus_size, bus_wdata);
    end
    bus_ack = 1;
    step();
    bus_ack = 0;
    checks++;
    if (trans_rdy !== 1'b1 || bus_req !== 1'b0) begin
      failures++; $display("FAIL write_done got tr=%b req=%b exp 1 0", trans_rdy, bus_req);
    end
    write_through_req = 0;
    repeat (2) step();
    checks++;
    if (n_tr - tr0 != 1) begin failures++; $display("FAIL write_pulses got=%0d exp=1", n_tr - tr0); end
  endtask

  task automatic test_fill_error();
    int lw0 = n_lw, cew0 = n_cew, tr0 = n_tr, be0 = n_be, ab0 = n_ab;
    read_line_req = 1; pa = 64'h4000_0100;
    for (int b = 0; b < 2; b++) begin
      wait_req("ferr_req");
      bus_ack = 1; bus_rdata = 64'hA0 + 64'(b);
      step();
      bus_ack = 0;
    end
    wait_req("ferr_req2");
    bus_err = 1;
    step();
    bus_err = 0;
    checks++;
    if (bus_error !== 1'b1 || line_fill_abort !== 1'b1 || trans_rdy !== 1'b0 || bus_req !== 1'b0) begin
      failures++; $display("FAIL ferr_pulse got be=%b ab=%b tr=%b req=%b exp 1 1 0 0", bus_error, line_fill_abort, trans_rdy, bus_req);
    end
    read_line_req = 0;
    repeat (3) step();
    checks++;
    if (n_lw - lw0 != 2 || n_cew != cew0 || n_tr != tr0 || n_be - be0 != 1 || n_ab - ab0 != 1) begin
      failures++; $display("FAIL ferr_counts got lw=%0d cew=%0d tr=%0d be=%0d ab=%0d exp 2 0 0 1 1", n_lw - lw0, n_cew - cew0, n_tr - tr0, n_be - be0, n_ab - ab0);
    end
  endtask

  task automatic test_timeout();
    int n = 0, ab0 = n_ab;
    read_req = 1; pa = 64'h1000_0040; L1_size = 4'b0001;
    wait_req("tmo_req");
    while (bus_req === 1'b1 && n < 20) begin n++; step(); end
    checks++;
    if (n != 8 || bus_error !== 1'b1 || trans_rdy !== 1'b0) begin
      failures++; $display("FAIL timeout got req_cycles=%0d be=%b tr=%b exp 8 1 0", n, bus_error, trans_rdy);
    end
    read_req = 0;
    repeat (2) step();
    checks++;
    if (bus_req !== 1'b0 || bus_error !== 1'b0 || n_ab != ab0) begin
      failures++; $display("FAIL timeout_after got req=%b be=%b exp 0 0", bus_req, bus_error);
    end
  endtask

  task automatic test_ack_err_together();
    write_through_req = 1; pa = 64'h2000_0020; wt_data = 64'h5; L1_size = 4'b0010;
    wait_req("both_req");
    bus_ack = 1; bus_err = 1;
    step();
    bus_ack = 0; bus_err = 0;
    checks++;
    if (bus_error !== 1'b1 || trans_rdy !== 1'b0) begin
      failures++; $display("FAIL ack_err got be=%b tr=%b exp 1 0", bus_error, trans_rdy);
    end
    write_through_req = 0;
    repeat (2) step();
  endtask

  task automatic test_reset_mid_fill();
    read_line_req = 1; pa = 64'h6000_0000;
    wait_req("rstf_req");
    bus_ack = 1; bus_rdata = 64'h77;
    step();
    bus_ack = 0;
    wait_req("rstf_req1");
    rst = 1;
    step();
    checks++;
    if ({line_data, addr_count, line_write, cache_entry_write, trans_rdy, bus_error, line_fill_abort,
         bus_req, bus_we, bus_addr, bus_size, bus_wdata} !== '0) begin
      failures++; $display("FAIL rst_mid got req=%b data=%0h cnt=%0d exp all 0", bus_req, line_data, addr_count);
    end
    bus_ack = 1; bus_rdata = 64'h99;
    step();
    bus_ack = 0; rst = 0; read_line_req = 0;
    step();
    read_req = 1; pa = 64'h3000_0008; L1_size = 4'b0001;
    wait_req("rstf_read");
    checks++;
    if (bus_addr !== 64'h3000_0008 || bus_size !== 4'b0001) begin
      failures++; $display("FAIL rst_read_bus got=%0h/%b exp 30000008/0001", bus_addr, bus_size);
    end
    bus_ack = 1; bus_rdata = 64'h55;
    step();
    bus_ack = 0;
    checks++;
    if (trans_rdy !== 1'b1 || line_data !== 64'h55) begin
      failures++; $display("FAIL rst_read_done got tr=%b data=%0h exp 1 55", trans_rdy, line_data);
    end
    read_req = 0;
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_read();
    test_write();
    test_fill_error();
    test_timeout();
    test_ack_err_together();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
